// File: rtl/gpo_seq_pkg.sv
// Shared constants for the GPO pattern sequencer: register map, bit fields, FSM states.
package gpo_seq_pkg;

   // CPU word addresses
   localparam logic [3:0] ADDR_CTRL     = 4'h0;
   localparam logic [3:0] ADDR_CFG      = 4'h1;
   localparam logic [3:0] ADDR_INTERVAL = 4'h2;
   localparam logic [3:0] ADDR_STATUS   = 4'h3;
   localparam logic [3:0] ADDR_DIRECT   = 4'h4;

   // Register bit positions
   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_STOP_BIT   = 1;
   localparam int unsigned CFG_LOOP_BIT    = 0;
   localparam int unsigned CFG_LAST_LSB    = 4;
   localparam int unsigned STATUS_BUSY_BIT = 0;
   localparam int unsigned STATUS_DONE_BIT = 1;
   localparam int unsigned STATUS_IDX_LSB  = 4;

   // Sequencer states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/gpo_seq_timer.sv
// Loadable down-counter used to space sequencer writes; zero_c flags an expired count.
module gpo_seq_timer #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero_c
);

   logic [W-1:0] cnt;

   // Load has priority over decrement; the count saturates at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/gpo_seq_ctrl.sv
// GPO pattern sequencer: CPU register file, pattern table and timed GPO write FSM.
// CPU DIRECT writes share the GPO strobe and always win over the sequencer.
module gpo_seq_ctrl #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = 3,
   parameter int unsigned INT_W = 24,
   parameter int unsigned GPO_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        wr,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        gpo_cs,
   output logic        gpo_wr,
   output logic [31:0] gpo_wdata,
   output logic        irq
);

   import gpo_seq_pkg::*;

   logic             cpu_wr;
   logic             direct_wr;
   logic             ctrl_wr;
   logic             status_wr;
   logic             start_req;
   logic             stop_req;
   logic             seq_wr;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [IDX_W-1:0] idx_adv;

   logic             cfg_loop;
   logic [IDX_W-1:0] cfg_last;
   logic [INT_W-1:0] interval;
   logic [INT_W-1:0] interval_m1;
   logic [GPO_W-1:0] pat [DEPTH];
   logic [GPO_W-1:0] last_gpo;
   logic             done;
   logic             done_set;

   logic             tmr_load;
   logic             tmr_dec;
   logic [INT_W-1:0] tmr_val;
   logic             tmr_zero;

   logic             unused_wdata;

   // CPU strobe decode; reset blocks any write reaching the GPO
   assign cpu_wr    = cs & wr & ~reset;
   assign direct_wr = cpu_wr & (addr == ADDR_DIRECT);
   assign ctrl_wr   = cpu_wr & (addr == ADDR_CTRL);
   assign status_wr = cpu_wr & (addr == ADDR_STATUS);
   assign stop_req  = ctrl_wr & wdata[CTRL_STOP_BIT];
   assign start_req = ctrl_wr & wdata[CTRL_START_BIT] & ~wdata[CTRL_STOP_BIT];
   assign seq_wr    = (state == ST_WRITE);

   // Spacing between writes is max(INTERVAL,1); one cycle is spent in WRITE
   assign interval_m1 = (interval == '0) ? '0 : interval - INT_W'(1);
   assign idx_adv     = (idx == cfg_last) ? '0 : idx + IDX_W'(1);

   assign unused_wdata = ^wdata[31:INT_W];

   // Interval timer between sequencer writes
   gpo_seq_timer #(
      .W (INT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero_c   (tmr_zero)
   );

   // Next-state logic; STOP beats START, both beat normal sequencing
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      tmr_val   = '0;
      done_set  = 1'b0;
      case (state)
         ST_IDLE: begin
         end
         ST_WRITE: begin
            // A colliding DIRECT write holds the sequencer write off by a cycle
            if (!direct_wr) begin
               if ((idx == cfg_last) && !cfg_loop) begin
                  state_nxt = ST_IDLE;
                  done_set  = 1'b1;
               end else if (interval_m1 == '0) begin
                  idx_nxt = idx_adv;
               end else begin
                  state_nxt = ST_WAIT;
                  tmr_load  = 1'b1;
                  tmr_val   = interval_m1 - INT_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (tmr_zero) begin
               state_nxt = ST_WRITE;
               idx_nxt   = idx_adv;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (stop_req) begin
         state_nxt = ST_IDLE;
         idx_nxt   = idx;
         done_set  = 1'b0;
      end else if (start_req) begin
         state_nxt = ST_WRITE;
         idx_nxt   = '0;
         done_set  = 1'b0;
      end
   end

   // FSM state and pattern index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Configuration and pattern table writes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_loop <= 1'b0;
         cfg_last <= '0;
         interval <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pat[i] <= '0;
         end
      end else if (cpu_wr) begin
         if (addr == ADDR_CFG) begin
            cfg_loop <= wdata[CFG_LOOP_BIT];
            cfg_last <= wdata[CFG_LAST_LSB +: IDX_W];
         end
         if (addr == ADDR_INTERVAL) begin
            interval <= wdata[INT_W-1:0];
         end
         if (addr[3]) begin
            pat[IDX_W'(addr[2:0])] <= wdata[GPO_W-1:0];
         end
      end
   end

   // DONE flag: set on sequence completion, write-1-to-clear, set wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done <= 1'b0;
      end else if (done_set) begin
         done <= 1'b1;
      end else if (status_wr && wdata[STATUS_DONE_BIT]) begin
         done <= 1'b0;
      end
   end

   // Shadow of the last value sent to the GPO from either source
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gpo <= '0;
      end else if (gpo_wr) begin
         last_gpo <= gpo_wdata[GPO_W-1:0];
      end
   end

   // GPO write path: DIRECT data takes priority over the pattern entry
   always_comb begin
      gpo_wdata = '0;
      if (direct_wr) begin
         gpo_wdata[GPO_W-1:0] = wdata[GPO_W-1:0];
      end else if (seq_wr) begin
         gpo_wdata[GPO_W-1:0] = pat[idx];
      end
   end

   assign gpo_wr = direct_wr | seq_wr;
   assign gpo_cs = gpo_wr;
   assign irq    = done;

   // CPU read mux
   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_CFG: begin
            rdata[CFG_LOOP_BIT]            = cfg_loop;
            rdata[CFG_LAST_LSB +: IDX_W]   = cfg_last;
         end
         ADDR_INTERVAL: begin
            rdata[INT_W-1:0] = interval;
         end
         ADDR_STATUS: begin
            rdata[STATUS_BUSY_BIT]         = (state != ST_IDLE);
            rdata[STATUS_DONE_BIT]         = done;
            rdata[STATUS_IDX_LSB +: IDX_W] = idx;
         end
         ADDR_DIRECT: begin
            rdata[GPO_W-1:0] = last_gpo;
         end
         default: begin
            if (addr[3]) begin
               rdata[GPO_W-1:0] = pat[IDX_W'(addr[2:0])];
            end
         end
      endcase
   end

endmodule

// File: doc/gpo_seq_ctrl.md
Name: gpo_seq_ctrl

Overview:
- Bus-slave/bus-master controller placed between the CPU peripheral bus and the 16-bit GPO output register.
- The CPU programs a small pattern table and a tick interval. The block then drives timed write strobes into the GPO, so output waveforms play without CPU involvement.
- CPU direct writes to the GPO are routed through this block and always take priority over sequencer writes.

Parameters:
- DEPTH, 8, number of pattern entries (power of two).
- IDX_W, 3, log2(DEPTH).
- INT_W, 24, interval counter width.
- GPO_W, 16, GPO data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  CPU select for this block.
- wr  in  1  CPU write strobe, qualified by cs.
- addr  in  4  CPU word address.
- wdata  in  32  CPU write data.
- rdata  out  32  CPU read data, combinational from addr.
- gpo_cs  out  1  select to GPO register.
- gpo_wr  out  1  write strobe to GPO register.
- gpo_wdata  out  32  data to GPO; bits [31:GPO_W] are 0.
- irq  out  1  level interrupt; equals the done flag.

Behaviour:
- Register map (word addresses):
  - 0x0 CTRL: write-only pulses. bit0 START, bit1 STOP. Reads 0.
  - 0x1 CFG: bit0 LOOP, bits[IDX_W+3:4] LAST index.
  - 0x2 INTERVAL: [INT_W-1:0].
  - 0x3 STATUS: bit0 BUSY, bit1 DONE (write 1 to bit1 clears it), bits[IDX_W+3:4] current index.
  - 0x4 DIRECT: writing forwards wdata[GPO_W-1:0] to GPO in the same cycle. Reads the last value written by either source.
  - 0x8-0xF: PAT[0..7], GPO_W bits each. Unused addresses read 0 and ignore writes.
- Reset: all registers 0, state IDLE. gpo_cs, gpo_wr, gpo_wdata, irq are all 0. Takes effect immediately at any point, including mid-sequence.
- gpo_cs/gpo_wr are combinational (a CPU DIRECT write, or the registered sequencer WRITE state). They are asserted together, for exactly one cycle per GPO write.
- FSM states: IDLE, WRITE, WAIT.
  - IDLE: START (cs&wr, addr 0x0, bit0) in cycle N → index=0, enter WRITE at N+1.
  - WRITE: drive PAT[index] for one cycle. Load count = max(INTERVAL,1)-1. Go to WAIT if count≠0, else stay in WRITE with the next index.
  - WAIT: decrement count each cycle. At count 0, advance the index and enter WRITE.
  - Net result: successive GPO writes are exactly max(INTERVAL,1) cycles apart. INTERVAL=0 behaves as 1.
- Index advance after the write of index==LAST:
  - LOOP=1: next index 0.
  - LOOP=0: go to IDLE, set DONE. DONE stays set until cleared or reset.
- Index wraps modulo DEPTH if LAST ≥ DEPTH (not reachable with default widths).
- Collision (DIRECT write in the same cycle as WRITE): the DIRECT data is written, and the sequencer stays in WRITE and issues its write next cycle. Interval timing restarts from the actual sequencer write.
- STOP in any state: go to IDLE next cycle, no further sequencer writes, DONE unchanged.
- START while busy: restart at index 0 (enter WRITE next cycle).
- START and STOP in the same write: STOP wins.
- DONE clear and DONE set in the same cycle: set wins.
- PAT/CFG/INTERVAL writes while busy are allowed:
  - PAT/CFG changes take effect at the next WRITE that reads them.
  - INTERVAL changes take effect at the next WRITE count load.
- BUSY = (state≠IDLE).

Decomposition:
- Shared package gpo_seq_pkg: register address constants, CTRL/CFG/STATUS bit positions, FSM state enum.
- One natural sub-module, gpo_seq_timer: loadable down-counter with a zero flag, INT_W wide.
- Register file and FSM stay in the top module.

Test Plan:
1. Reset mid-sequence (after 3 writes): assert reset → gpo_cs=0, irq=0, STATUS=0 immediately; no GPO write after release.
2. PAT0..3 = 0x0001, 0x0002, 0x0004, 0x0008; LAST=3; LOOP=0; INTERVAL=5; START at cycle N → gpo_wr pulses at N+1, N+6, N+11, N+16 with those values; DONE/irq=1 at N+17; BUSY=0.
3. INTERVAL=0, LAST=1, LOOP=1, PAT0=0xAAAA, PAT1=0x5555 → gpo_wr high every cycle, data alternating; STOP → no writes from the cycle after STOP; DONE stays 0.
4. DIRECT write of 0x1234 in the same cycle as a sequencer WRITE of PAT2=0x00F0 → 0x1234 written that cycle, 0x00F0 next cycle; the following write comes INTERVAL cycles after that.
5. START while busy at index 2 → next write is PAT0 one cycle later; STATUS index reads 0.
6. DONE set, write STATUS bit1=1 → irq=0 next cycle; a write of 0x000F to addr 0xA reads back 0x0000000F; addr 0x5 reads 0.
